// File: rtl/spi_frame_ctrl_if.sv
// Register-bank bus between the SPI frame controller and a register file.
// Latency: reg_rdata is combinational from the bank while reg_re is high.
// Backpressure: none; the bank must accept every reg_we/reg_re strobe.
//
// Signals:
//   reg_addr  - register address of the current frame
//   reg_wdata - write data, valid while reg_we is high and held afterwards
//   reg_we    - one-cycle write strobe
//   reg_re    - one-cycle read strobe
//   reg_rdata - read data returned by the bank during reg_re
// Modports: master = frame controller side, slave = register bank side.
interface spi_frame_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 slave that decodes 16-bit frames into register-bank accesses.
// Latency: SYNC_STAGES+1 clk from an SPI pin edge to its internal event; strobes follow one clk later.
// Backpressure: none; the SPI master sets the pace and the register bank must accept every strobe.
//
// Frame: command byte (bit7 = R/W with 1 = read, bits6..0 = address) then a data byte, MSB first.
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi  - SPI inputs, asynchronous to clk, synchronized internally
//   spi_miso            - SPI data out, driven only during the data byte of a read frame
//   bus                 - register-bank master port (addr, wdata, we, re, rdata)
//   frame_err           - one-cycle pulse when chip select rises in the middle of a frame
module spi_frame_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_sclk,
  input  logic                      spi_cs_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  spi_frame_ctrl_if.master          bus,
  output logic                      frame_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA    = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Reset values match an idle bus: sclk low, cs_n high.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [3:0] bit_cnt;
  logic       start;
  logic       shift_en;
  logic       cmd_last;
  logic       data_last;
  logic       abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // cs_rise is tested before sclk_rise so a coincident clock edge is dropped
  // together with the aborted frame.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    cmd_last  = 1'b0;
    data_last = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          start     = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd7) begin
            cmd_last  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd15) begin
            data_last = 1'b1;
            state_nxt = WAIT_CS;
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. shift_in only needs the 7 bits seen before the last bit of a
  // byte: the 8th bit is taken straight from mosi_s on the completing edge.
  // ---------------------------------------------------------------------------
  logic [6:0]        shift_in;
  logic [7:0]        shift_out;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              we_q;
  logic              re_q;
  logic              err_q;
  logic              miso_q;
  logic              read_data_phase;

  assign read_data_phase = (state == DATA) && rw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 4'd0;
      shift_in  <= 7'd0;
      shift_out <= 8'd0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'd0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      err_q     <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      re_q  <= 1'b0;
      err_q <= abort;

      if (start) begin
        bit_cnt  <= 4'd0;
        shift_in <= 7'd0;
      end else if (shift_en) begin
        bit_cnt  <= bit_cnt + 4'd1;
        shift_in <= {shift_in[5:0], mosi_s};
      end

      // Address and R/W become visible the cycle after the 8th rising edge;
      // a read strobe is issued in that same cycle.
      if (cmd_last) begin
        addr_q <= {shift_in[ADDR_W-2:0], mosi_s};
        rw_q   <= shift_in[6];
        re_q   <= shift_in[6];
      end

      if (data_last && !rw_q) begin
        wdata_q <= {shift_in, mosi_s};
        we_q    <= 1'b1;
      end

      // Read data is captured while reg_re is high, then shifted out MSB
      // first, one bit per falling sclk edge.
      if (re_q) begin
        shift_out <= bus.reg_rdata;
      end else if (read_data_phase && sclk_fall) begin
        shift_out <= {shift_out[6:0], 1'b0};
      end

      if (read_data_phase) begin
        if (sclk_fall) begin
          miso_q <= shift_out[7];
        end
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign frame_err     = err_q;
  assign spi_miso      = miso_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: table of frames plus reset and back-to-back sequences.
module tb_spi_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       frame_err;
  logic [7:0] rdata_v;

  spi_frame_ctrl_if #(.ADDR_W(7)) bus ();
  assign bus.reg_rdata = rdata_v;

  spi_frame_ctrl #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .bus       (bus),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Pulse monitor: running totals, written only here.
  int         we_tot   = 0;
  int         re_tot   = 0;
  int         err_tot  = 0;
  int         viol_tot = 0;
  logic       we_prev  = 1'b0;
  logic       re_prev  = 1'b0;
  logic       err_prev = 1'b0;
  logic [7:0] we_log[$];

  always @(negedge clk) begin
    if (bus.reg_we) begin
      we_tot = we_tot + 1;
      we_log.push_back(bus.reg_wdata);
    end
    if (bus.reg_re)  re_tot  = re_tot + 1;
    if (frame_err)   err_tot = err_tot + 1;
    if ((bus.reg_we && we_prev) || (bus.reg_re && re_prev) || (frame_err && err_prev) ||
        (int'(bus.reg_we) + int'(bus.reg_re) + int'(frame_err) > 1))
      viol_tot = viol_tot + 1;
    we_prev  = bus.reg_we;
    re_prev  = bus.reg_re;
    err_prev = frame_err;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame, sclk period 8 clk. Stops after abort_at rising edges if
  // abort_at < nbits. Bits past 16 are driven as 1. Returns the miso bits
  // sampled before rising edges 9..16 and an OR of miso during the command.
  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] dat,
                           input int nbits, input int abort_at, input int gap,
                           output logic [7:0] miso_byte, output logic miso_cmd);
    logic b;
    miso_byte = 8'h00;
    miso_cmd  = 1'b0;
    spi_cs_n  = 1'b0;
    clks(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) break;
      if (i < 8)       b = cmd[7-i];
      else if (i < 16) b = dat[15-i];
      else             b = 1'b1;
      spi_mosi = b;
      clks(4);
      if (i < 8)               miso_cmd = miso_cmd | spi_miso;
      else if (i < 16)         miso_byte[15-i] = spi_miso;
      spi_sclk = 1'b1;
      clks(4);
      spi_sclk = 1'b0;
    end
    clks(4);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    clks(gap);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] rdata;
    int         nbits;
    int         abort_at;
    int         exp_we;
    int         exp_re;
    int         exp_err;
    logic [6:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] mb;
    logic       mc;
    int we0, re0, err0, viol0;

    //            cmd    dat    rdata  nb  abort we re err addr   wdata  miso
    vecs[0] = '{8'h15, 8'hA5, 8'h00, 16, 99,   1, 0, 0, 7'h15, 8'hA5, 8'h00};
    vecs[1] = '{8'h83, 8'h00, 8'h3C, 16, 99,   0, 1, 0, 7'h03, 8'hA5, 8'h3C};
    vecs[2] = '{8'h20, 8'h77, 8'h00, 16, 11,   0, 0, 1, 7'h20, 8'hA5, 8'h00};
    vecs[3] = '{8'h01, 8'hFF, 8'h00, 16, 99,   1, 0, 0, 7'h01, 8'hFF, 8'h00};
    vecs[4] = '{8'h02, 8'h5A, 8'h00, 20, 99,   1, 0, 0, 7'h02, 8'h5A, 8'h00};
    vecs[5] = '{8'h85, 8'h00, 8'h99, 16, 4,    0, 0, 1, 7'h02, 8'h5A, 8'h00};
    vecs[6] = '{8'hFF, 8'h00, 8'hA1, 16, 99,   0, 1, 0, 7'h7F, 8'h5A, 8'hA1};

    rst_n    = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    rdata_v  = 8'h00;
    clks(3);
    chk("reset reg_addr",  int'(bus.reg_addr),  0);
    chk("reset reg_wdata", int'(bus.reg_wdata), 0);
    chk("reset reg_we",    int'(bus.reg_we),    0);
    chk("reset reg_re",    int'(bus.reg_re),    0);
    chk("reset frame_err", int'(frame_err),     0);
    chk("reset spi_miso",  int'(spi_miso),      0);
    rst_n = 1'b1;
    clks(5);

    for (int v = 0; v < 7; v++) begin
      we0 = we_tot; re0 = re_tot; err0 = err_tot; viol0 = viol_tot;
      rdata_v = vecs[v].rdata;
      spi_frame(vecs[v].cmd, vecs[v].dat, vecs[v].nbits, vecs[v].abort_at, 8, mb, mc);
      chk($sformatf("v%0d we pulses", v),  we_tot - we0,   vecs[v].exp_we);
      chk($sformatf("v%0d re pulses", v),  re_tot - re0,   vecs[v].exp_re);
      chk($sformatf("v%0d err pulses", v), err_tot - err0, vecs[v].exp_err);
      chk($sformatf("v%0d strobe shape", v), viol_tot - viol0, 0);
      chk($sformatf("v%0d reg_addr", v),   int'(bus.reg_addr),  int'(vecs[v].exp_addr));
      chk($sformatf("v%0d reg_wdata", v),  int'(bus.reg_wdata), int'(vecs[v].exp_wdata));
      chk($sformatf("v%0d miso data", v),  int'(mb), int'(vecs[v].exp_miso));
      chk($sformatf("v%0d miso cmd", v),   int'(mc), 0);
    end

    // Reset after 6 bits of a write frame.
    we0 = we_tot; re0 = re_tot; err0 = err_tot;
    spi_cs_n = 1'b0;
    clks(4);
    for (int i = 0; i < 6; i++) begin
      spi_mosi = i[0];
      clks(4);
      spi_sclk = 1'b1;
      clks(4);
      spi_sclk = 1'b0;
    end
    clks(2);
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #1;
    chk("midrst reg_addr",  int'(bus.reg_addr),  0);
    chk("midrst reg_wdata", int'(bus.reg_wdata), 0);
    chk("midrst spi_miso",  int'(spi_miso),      0);
    clks(3);
    rst_n = 1'b1;
    clks(10);
    chk("midrst no strobe", (we_tot - we0) + (re_tot - re0) + (err_tot - err0), 0);
    spi_frame(8'h7F, 8'h11, 16, 99, 8, mb, mc);
    chk("post-rst we pulses", we_tot - we0,   1);
    chk("post-rst err",       err_tot - err0, 0);
    chk("post-rst reg_addr",  int'(bus.reg_addr),  8'h7F);
    chk("post-rst reg_wdata", int'(bus.reg_wdata), 8'h11);

    // Back-to-back frames with cs_n high for SYNC_STAGES+1 clk.
    we0 = we_tot; err0 = err_tot; viol0 = viol_tot;
    spi_frame(8'h10, 8'h22, 16, 99, 3, mb, mc);
    spi_frame(8'h11, 8'h33, 16, 99, 8, mb, mc);
    chk("b2b we pulses", we_tot - we0,     2);
    chk("b2b err",       err_tot - err0,   0);
    chk("b2b shape",     viol_tot - viol0, 0);
    chk("b2b reg_addr",  int'(bus.reg_addr), 8'h11);
    if (we_log.size() >= 2) begin
      chk("b2b first wdata",  int'(we_log[we_log.size()-2]), 8'h22);
      chk("b2b second wdata", int'(we_log[we_log.size()-1]), 8'h33);
    end else begin
      chk("b2b wdata log size", we_log.size(), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on spi_sclk, spi_cs_n and spi_mosi; legal range 2..3.
REQ-002 Parameter ADDR_W, default 7: register address width; the command byte is 1 R/W bit plus ADDR_W address bits, so ADDR_W+1 = 8.
REQ-003 clk  input  1  system clock; one clock drives all logic.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 spi_sclk  input  1  SPI clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-006 spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 spi_mosi  input  1  SPI serial data in, MSB first.
REQ-008 spi_miso  output  1  SPI serial data out, MSB first.
REQ-009 reg_addr  output  ADDR_W  register address of the current frame.
REQ-010 reg_wdata  output  8  write data.
REQ-011 reg_we  output  1  one-cycle write strobe.
REQ-012 reg_re  output  1  one-cycle read strobe; reg_rdata is sampled in the same cycle.
REQ-013 reg_rdata  input  8  read data from the register bank, valid combinationally while reg_re is high.
REQ-014 frame_err  output  1  one-cycle pulse on an aborted frame.

Function
REQ-015 Each SPI input passes through SYNC_STAGES flops; all internal logic uses only the synchronized copies.
REQ-016 Internal single-cycle events come from the synchronized signals:
- sclk_rise and sclk_fall: edges of the synchronized sclk.
- cs_fall and cs_rise: edges of the synchronized cs_n.
- Each event is derived from the current and previous synchronized values.
REQ-017 Frame format: 8-bit command (bit7 = R/W, 1 = read; bits6..0 = address), then 8-bit data, 16 bits total.
REQ-018 FSM states: IDLE, CMD, DATA, WAIT_CS.
REQ-019 IDLE -> CMD on cs_fall; the bit counter clears to 0 and the shift-in register clears to 0.
REQ-020 In CMD and DATA, each sclk_rise shifts the synchronized mosi into the shift-in LSB and increments the 4-bit bit counter.
REQ-021 CMD -> DATA on the 8th sclk_rise; the next cycle latches reg_addr and the R/W flag.
REQ-022 For a read, reg_re pulses for exactly one cycle in that same cycle; reg_rdata is loaded into the shift-out register.
REQ-023 In a read frame, spi_miso changes only on sclk_fall and presents shift-out MSB first.
- The first data bit appears on the sclk_fall after the 8th sclk_rise.
REQ-024 In CMD, and in write frames, spi_miso = 0.
REQ-025 DATA -> WAIT_CS on the 16th sclk_rise.
- Write: reg_wdata latches the data byte, and reg_we pulses for one cycle in the cycle after that sclk_rise.
- Read: no strobe.
REQ-026 In WAIT_CS, further sclk edges are ignored and the outputs hold, with spi_miso = 0; WAIT_CS -> IDLE on cs_rise, with no error.
REQ-027 cs_rise in CMD or DATA aborts the frame: return to IDLE, frame_err pulses one cycle, and no reg_we is issued.
REQ-028 If cs_rise and sclk_rise occur in the same cycle, cs_rise wins: the frame aborts and the bit is discarded.
REQ-029 reg_we, reg_re and frame_err are never high for more than one consecutive cycle; at most one of them is asserted per frame.
REQ-030 reg_addr and reg_wdata hold their last values until they are next updated.

Reset
REQ-031 While rst_n = 0:
- FSM = IDLE and bit counter = 0.
- Synchronizer flops: sclk stages = 0, cs_n stages = 1, mosi stages = 0.
- reg_addr = 0, reg_wdata = 0, reg_we = 0, reg_re = 0, frame_err = 0, spi_miso = 0.
REQ-032 Reset asserted mid-frame discards the frame with no strobe and no frame_err.
- After release, the first cs_fall is required before any frame is accepted.

Verification
REQ-033 Write frame: cs low, shift 0x15 then 0xA5 (sclk period 8 clk), cs high.
- Exactly one reg_we pulse, with reg_addr = 0x15 and reg_wdata = 0xA5.
- reg_re = 0 and frame_err = 0 throughout.
REQ-034 Read frame: shift 0x83 then 8 dummy bits, with reg_rdata = 0x3C at the reg_re pulse.
- One reg_re pulse with reg_addr = 0x03.
- The miso bits sampled on sclk rising edges are 0,0,1,1,1,1,0,0.
REQ-035 Abort: cs rises after 11 sclk rising edges of a write frame.
- frame_err pulses once, reg_we stays 0, and the FSM returns to IDLE.
- The next full frame (0x01, 0xFF) writes normally.
REQ-036 Overlong frame: 20 sclk edges with cs low, write 0x02/0x5A.
- One reg_we with wdata 0x5A; the extra 4 bits are ignored.
- No frame_err at cs_rise.
REQ-037 Reset mid-frame: rst_n low for 3 clk after 6 bits.
- All outputs go to 0 immediately; no strobe follows.
- A subsequent write 0x7F/0x11 completes correctly.
REQ-038 Back-to-back frames with cs high for only SYNC_STAGES+1 clk: both frames are decoded, giving two distinct reg_we pulses.
